// File: rtl/stump_sequencer.sv
// stump_sequencer: FETCH/EXECUTE/MEMORY control sequencer for the Stump datapath,
// with branch-condition evaluation and a memory-handshake timeout that halts on bus error.
module stump_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
  input  logic        mem_ready,
  output logic [1:0]  state,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_write,
  output logic        cc_en,
  output logic        mem_req,
  output logic        mem_write,
  output logic        branch_taken,
  output logic        halted,
  output logic        bus_error
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, MEM = 2'b10, HALT = 2'b11} state_t;
  state_t cur, nxt;
  logic [7:0] cnt;
  logic [2:0] op;
  logic waiting, tmo, taken;
  logic unused_ir;
  // Conditions come in complementary pairs: bit 0 of the code inverts the base test.
  function automatic logic cond_true(input logic [3:0] code, input logic [3:0] f);
    logic n, z, v, c, t;
    {n, z, v, c} = f;
    case (code[3:1])
      3'd0: t = 1'b1;
      3'd1: t = ~(c | z);
      3'd2: t = ~c;
      3'd3: t = ~z;
      3'd4: t = ~v;
      3'd5: t = ~n;
      3'd6: t = (n == v);
      default: t = ~z & (n == v);
    endcase
    return t ^ code[0];
  endfunction
  assign op = ir[15:13];
  assign unused_ir = ^{ir[12], ir[7:0]};
  assign state = cur;
  assign halted = (cur == HALT);
  assign taken = cond_true(ir[11:8], cc);
  assign waiting = (cur == FETCH) || (cur == MEM);
  assign tmo = waiting && !mem_ready && (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur <= HALT;
      cnt <= 8'd0;
      bus_error <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur || mem_ready || !waiting) ? 8'd0 : cnt + 8'd1;
      bus_error <= bus_error | tmo;
    end
  end
  always_comb begin
    nxt = cur;
    ir_en = 1'b0;
    pc_en = 1'b0;
    reg_write = 1'b0;
    cc_en = 1'b0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    branch_taken = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
          nxt = EXEC;
        end else if (tmo) nxt = HALT;
      end
      EXEC: begin
        if (op == 3'b110) nxt = MEM;
        else begin
          reg_write = (op != 3'b111);
          cc_en = (op != 3'b111) & ir[11];
          branch_taken = (op == 3'b111) & taken;
          pc_en = branch_taken;
          nxt = run ? FETCH : HALT;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_write = ir[11];
        if (mem_ready) begin
          reg_write = ~ir[11];
          nxt = run ? FETCH : HALT;
        end else if (tmo) nxt = HALT;
      end
      default: nxt = (run && !bus_error) ? FETCH : HALT;
    endcase
  end
endmodule

// File: tb/tb_stump_sequencer.sv
// tb_stump_sequencer: directed and randomized checks of stump_sequencer against a
// behavioural instruction-step model.
module tb_stump_sequencer;
  localparam int TMO = 4;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        run = 1'b0;
  logic [15:0] ir = 16'h0;
  logic [3:0]  cc = 4'h0;
  logic        mem_ready = 1'b0;
  logic [1:0]  state;
  logic ir_en, pc_en, reg_write, cc_en, mem_req, mem_write, branch_taken, halted, bus_error;
  int total = 0, bad = 0;
  int ms = 3, waits = 0;
  bit be = 1'b0, last_ir_en = 1'b0;
  stump_sequencer #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .run(run), .ir(ir), .cc(cc), .mem_ready(mem_ready),
    .state(state), .ir_en(ir_en), .pc_en(pc_en), .reg_write(reg_write), .cc_en(cc_en),
    .mem_req(mem_req), .mem_write(mem_write), .branch_taken(branch_taken),
    .halted(halted), .bus_error(bus_error)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b (st,ir,pc,rw,cc,req,wr,br,hlt,be)", tag, $time, got, exp);
    end
  endtask
  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit n = f[3], z = f[2], v = f[1], c = f[0];
    case (code)
      4'd0: return 1;
      4'd1: return 0;
      4'd2: return !(c || z);
      4'd3: return c || z;
      4'd4: return !c;
      4'd5: return c;
      4'd6: return !z;
      4'd7: return z;
      4'd8: return !v;
      4'd9: return v;
      4'd10: return !n;
      4'd11: return n;
      4'd12: return n == v;
      4'd13: return n != v;
      4'd14: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction
  // One clock: drive inputs at the falling edge, check outputs 1 ns later, advance the model at the rising edge.
  task automatic cyc(input string tag, input bit r, input logic [15:0] i, input logic [3:0] c,
                     input bit rdy, input bit rs);
    bit e_ir, e_pc, e_rw, e_cc, e_req, e_wr, e_br, expired;
    int op, nx;
    @(negedge CLK);
    run = r; ir = i; cc = c; mem_ready = rdy; RST = rs;
    #1;
    if (rs) begin ms = 3; waits = 0; be = 0; end
    {e_ir, e_pc, e_rw, e_cc, e_req, e_wr, e_br} = '0;
    op = int'(i[15:13]);
    expired = (ms == 0 || ms == 2) && !rdy && (waits + 1 >= TMO);
    nx = ms;
    if (ms == 0) begin
      e_req = 1;
      if (rdy) begin e_ir = 1; e_pc = 1; nx = 1; end
      else if (expired) nx = 3;
    end else if (ms == 1) begin
      if (op == 6) nx = 2;
      else begin
        if (op == 7) begin e_br = cond_ok(i[11:8], c); e_pc = e_br; end
        else begin e_rw = 1; e_cc = i[11]; end
        nx = r ? 0 : 3;
      end
    end else if (ms == 2) begin
      e_req = 1; e_wr = i[11];
      if (rdy) begin e_rw = !i[11]; nx = r ? 0 : 3; end
      else if (expired) nx = 3;
    end else if (r && !be) nx = 0;
    chk(tag, {state, ir_en, pc_en, reg_write, cc_en, mem_req, mem_write & mem_req, branch_taken, halted, bus_error},
        {2'(ms), e_ir, e_pc, e_rw, e_cc, e_req, e_wr, e_br, ms == 3, be});
    last_ir_en = e_ir;
    @(posedge CLK);
    if (!rs) begin
      waits = (nx == ms && (ms == 0 || ms == 2) && !rdy) ? waits + 1 : 0;
      be = be | expired;
      ms = nx;
    end
  endtask
  initial begin
    logic [15:0] cur_ir;
    cyc("reset", 0, 16'h0, 4'h0, 0, 1);
    cyc("reset", 0, 16'h0, 4'h0, 0, 1);
    repeat (5) cyc("idle", 0, 16'h0, 4'h0, 0, 0);
    cyc("start", 1, 16'h0, 4'h0, 0, 0);
    cyc("add_s_fetch", 1, 16'h0800, 4'h0, 1, 0);
    cyc("add_s_exec", 1, 16'h0800, 4'h0, 0, 0);
    cyc("add_fetch", 1, 16'h0000, 4'h0, 1, 0);
    cyc("add_exec", 1, 16'h0000, 4'h0, 0, 0);
    cyc("beq_fetch", 1, 16'hE700, 4'b0100, 1, 0);
    cyc("beq_taken", 1, 16'hE700, 4'b0100, 0, 0);
    cyc("beq_fetch", 1, 16'hE700, 4'b0000, 1, 0);
    cyc("beq_not", 1, 16'hE700, 4'b0000, 0, 0);
    cyc("bge_fetch", 1, 16'hEC00, 4'b1010, 1, 0);
    cyc("bge_taken", 1, 16'hEC00, 4'b1010, 0, 0);
    cyc("ld_fetch", 1, 16'hC000, 4'h0, 1, 0);
    cyc("ld_exec", 1, 16'hC000, 4'h0, 0, 0);
    repeat (3) cyc("ld_wait", 1, 16'hC000, 4'h0, 0, 0);
    cyc("ld_done", 1, 16'hC000, 4'h0, 1, 0);
    cyc("st_fetch", 1, 16'hC800, 4'h0, 1, 0);
    cyc("st_exec", 1, 16'hC800, 4'h0, 0, 0);
    cyc("st_done", 1, 16'hC800, 4'h0, 1, 0);
    repeat (TMO) cyc("timeout", 1, 16'h0, 4'h0, 0, 0);
    repeat (4) cyc("be_hold", 1, 16'h0, 4'h0, 1, 0);
    cyc("be_clear", 1, 16'h0, 4'h0, 0, 1);
    cyc("restart", 1, 16'h0, 4'h0, 0, 0);
    cyc("stop_fetch", 1, 16'h0000, 4'h0, 1, 0);
    cyc("stop_exec", 0, 16'h0000, 4'h0, 0, 0);
    cyc("stopped", 0, 16'h0000, 4'h0, 1, 0);
    cyc("restart", 1, 16'hC000, 4'h0, 0, 0);
    cyc("rstm_fetch", 1, 16'hC000, 4'h0, 1, 0);
    cyc("rstm_exec", 1, 16'hC000, 4'h0, 0, 0);
    cyc("rstm_mem", 1, 16'hC000, 4'h0, 0, 0);
    cyc("rst_in_mem", 1, 16'hC000, 4'h0, 0, 1);
    cur_ir = 16'($urandom);
    repeat (4000) begin
      if (last_ir_en) cur_ir = 16'($urandom);
      cyc("rand", ($urandom % 8) != 0, cur_ir, 4'($urandom), ($urandom % 10) < 6,
          ($urandom % 64) == 0 || (be && ($urandom % 8) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
